pattern_generator: RTL and testbench

//  Parametrised test-word source; next generation of the 10-bit counter source.
//  - Produces a burst or a continuous stream of DATA_W-bit words toward the serialiser/transmitter.
//  - Output uses a valid/ready handshake. A word advances only when the downstream accepts it.
//  - Four selectable patterns: up-count, down-count, maximal LFSR, walking-one.

---
 rtl/patgen_pkg.sv | 18 +
 rtl/patgen_next_word.sv | 24 ++
 rtl/pattern_generator.sv | 118 +++++++++++
 tb/tb_pattern_generator.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/patgen_pkg.sv
// rtl/patgen_pkg.sv - shared mode/state encodings and default LFSR taps for the pattern generator
package patgen_pkg;

  localparam logic [1:0] MODE_UP   = 2'd0;
  localparam logic [1:0] MODE_DOWN = 2'd1;
  localparam logic [1:0] MODE_LFSR = 2'd2;
  localparam logic [1:0] MODE_WALK = 2'd3;

  // x^10 + x^7 + 1, maximal length (1023) for a 10-bit register
  localparam logic [9:0] LFSR_TAPS_10 = 10'h240;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/patgen_next_word.sv
// rtl/patgen_next_word.sv - combinational next-word function for the four test patterns
module patgen_next_word
  import patgen_pkg::*;
#(
  parameter int                DATA_W    = 10,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(LFSR_TAPS_10)
) (
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] next_d
);

  always_comb begin
    next_d = d;
    case (mode)
      MODE_UP:   next_d = d + DATA_W'(1);
      MODE_DOWN: next_d = d - DATA_W'(1);
      MODE_LFSR: next_d = {d[DATA_W-2:0], ^(d & LFSR_TAPS)};
      MODE_WALK: next_d = {d[DATA_W-2:0], d[DATA_W-1]};
      default:   next_d = d;
    endcase
  end

endmodule

// File: rtl/pattern_generator.sv
// rtl/pattern_generator.sv - burst/continuous test-word source with valid/ready output
// Optional even-parity output o_parity when PATGEN_PARITY_EN is defined.
module pattern_generator
  import patgen_pkg::*;
#(
  parameter int                DATA_W    = 10,
  parameter int                LEN_W     = 16,
  parameter logic [DATA_W-1:0] LFSR_TAPS = DATA_W'(LFSR_TAPS_10)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stop,
  input  logic [1:0]        i_mode,
  input  logic [DATA_W-1:0] i_seed,
  input  logic [LEN_W-1:0]  i_len,
  input  logic              i_ready,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_busy,
  output logic              o_done,
  output logic [LEN_W-1:0]  o_word_cnt
`ifdef PATGEN_PARITY_EN
  ,
  output logic              o_parity
`endif
);

  state_t            state;
  logic [1:0]        mode_q;
  logic [LEN_W-1:0]  len_q;
  logic              stop_seen;
  logic [DATA_W-1:0] data_next;
  logic [DATA_W-1:0] seed_inc;
  logic [DATA_W-1:0] seed_clean;
  logic [LEN_W-1:0]  cnt_inc;
  logic              hs;
  logic              stop_pending;
  logic              last_word;

  patgen_next_word #(.DATA_W(DATA_W), .LFSR_TAPS(LFSR_TAPS)) u_next (
    .mode   (mode_q),
    .d      (o_data),
    .next_d (data_next)
  );

  // Up-count of a zero seed yields 1, the lock-up-free replacement seed
  patgen_next_word #(.DATA_W(DATA_W), .LFSR_TAPS(LFSR_TAPS)) u_seed (
    .mode   (MODE_UP),
    .d      (i_seed),
    .next_d (seed_inc)
  );

  assign seed_clean   = ((i_mode == MODE_LFSR || i_mode == MODE_WALK) && i_seed == '0)
                        ? seed_inc : i_seed;
  assign hs           = o_valid & i_ready;
  assign cnt_inc      = o_word_cnt + LEN_W'(1);
  assign stop_pending = stop_seen | i_stop;
  assign last_word    = (len_q != '0) && (cnt_inc == len_q);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= IDLE;
      mode_q     <= MODE_UP;
      len_q      <= '0;
      stop_seen  <= 1'b0;
      o_valid    <= 1'b0;
      o_data     <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
      o_word_cnt <= '0;
`ifdef PATGEN_PARITY_EN
      o_parity   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          o_done <= 1'b0;
          if (i_start && !i_stop) begin
            state      <= RUN;
            mode_q     <= i_mode;
            len_q      <= i_len;
            stop_seen  <= 1'b0;
            o_data     <= seed_clean;
            o_word_cnt <= '0;
            o_valid    <= 1'b1;
            o_busy     <= 1'b1;
`ifdef PATGEN_PARITY_EN
            o_parity   <= ^seed_clean;
`endif
          end
        end
        RUN: begin
          if (i_stop) stop_seen <= 1'b1;
          if (hs) begin
            o_data     <= data_next;
            o_word_cnt <= cnt_inc;
`ifdef PATGEN_PARITY_EN
            o_parity   <= ^data_next;
`endif
            if (last_word || stop_pending) begin
              state   <= DONE;
              o_valid <= 1'b0;
              o_busy  <= 1'b0;
              o_done  <= 1'b1;
            end
          end
        end
        DONE: begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pattern_generator.sv
// tb/tb_pattern_generator.sv - randomized self-checking bench against a word-index reference model
module tb_pattern_generator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0;
  logic        i_stop = 1'b0;
  logic [1:0]  i_mode = 2'd0;
  logic [9:0]  i_seed = '0;
  logic [15:0] i_len = '0;
  logic        i_ready = 1'b0;
  logic        o_valid;
  logic [9:0]  o_data;
  logic        o_busy;
  logic        o_done;
  logic [15:0] o_word_cnt;
`ifdef PATGEN_PARITY_EN
  logic        o_parity;
`endif

  int checks = 0;
  int errors = 0;

  pattern_generator dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (i_start),
    .i_stop     (i_stop),
    .i_mode     (i_mode),
    .i_seed     (i_seed),
    .i_len      (i_len),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_word_cnt (o_word_cnt)
`ifdef PATGEN_PARITY_EN
    ,
    .o_parity   (o_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a burst is described by (mode, seed, len) and the k-th word is computed directly
  logic        m_active = 1'b0;
  logic        m_done_due = 1'b0;
  logic        m_stop = 1'b0;
  logic [1:0]  m_mode = 2'd0;
  logic [9:0]  m_seed = '0;
  logic [15:0] m_len = '0;
  logic [15:0] m_idx = '0;
  logic        prev_hold = 1'b0;
  logic [9:0]  prev_data = '0;
  logic        next_done;
  logic [9:0]  lfsr_tab [4096];
  logic [9:0]  acc_q [$];
  logic [9:0]  vq [$];
  int          done_cnt = 0;

  task automatic build_lfsr(input logic [9:0] s);
    logic [9:0] v;
    v = s;
    for (int i = 0; i < 4096; i++) begin
      lfsr_tab[i] = v;
      v = {v[8:0], v[9] ^ v[6]};
    end
  endtask

  function automatic logic [9:0] word_at(input logic [1:0] mode, input logic [9:0] s,
                                         input logic [15:0] k);
    logic [19:0] two;
    case (mode)
      2'd0: return s + k[9:0];
      2'd1: return s - k[9:0];
      2'd2: return lfsr_tab[k[11:0]];
      default: begin
        two = {s, s} << (k % 10);
        return two[19:10];
      end
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_valid", o_valid, 0);
      chk("rst_busy", o_busy, 0);
      chk("rst_done", o_done, 0);
      chk("rst_data", o_data, 0);
      chk("rst_cnt", o_word_cnt, 0);
      m_active = 0; m_done_due = 0; m_stop = 0; m_idx = 0; prev_hold = 0;
    end else begin
      chk("valid", o_valid, m_active);
      chk("busy", o_busy, m_active);
      chk("done", o_done, m_done_due);
      chk("word_cnt", o_word_cnt, m_idx);
      if (m_active) chk("data", o_data, word_at(m_mode, m_seed, m_idx));
      if (prev_hold) chk("hold", o_data, prev_data);
      if (o_valid) vq.push_back(o_data);
      if (o_done) done_cnt++;
      prev_hold = m_active && !i_ready;
      prev_data = o_data;
      next_done = 0;
      if (m_active) begin
        m_stop = m_stop | i_stop;
        if (i_ready) begin
          acc_q.push_back(o_data);
          m_idx = m_idx + 16'd1;
          if (m_stop || (m_len != 0 && m_idx == m_len)) begin
            m_active = 0;
            next_done = 1;
          end
        end
      end else if (!m_done_due && i_start && !i_stop) begin
        m_active = 1; m_idx = 0; m_stop = 0;
        m_mode = i_mode; m_len = i_len;
        m_seed = (i_mode >= 2 && i_seed == 0) ? 10'd1 : i_seed;
        if (i_mode == 2'd2) build_lfsr(m_seed);
      end
      m_done_due = next_done;
    end
`ifdef PATGEN_PARITY_EN
    chk("parity", o_parity, ^o_data);
`endif
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_burst(input logic [1:0] mode, input logic [9:0] seed, input logic [15:0] len);
    acc_q.delete();
    vq.delete();
    i_mode = mode; i_seed = seed; i_len = len; i_start = 1;
    step(1);
    i_start = 0;
  endtask

  task automatic wait_done(input int budget);
    int d0;
    int n;
    d0 = done_cnt;
    n = 0;
    while (done_cnt == d0 && n < budget) begin
      step(1);
      n++;
    end
    chk("done_seen", done_cnt != d0, 1);
    step(2);
  endtask

  initial begin
    int n;
    int zeros;
    int d0;
    step(2);
    rst = 0;
    step(2);

    // Up-count across the wrap with one back-pressured cycle
    i_ready = 1;
    d0 = done_cnt;
    start_burst(2'd0, 10'd1020, 16'd6);
    step(2);
    i_ready = 0;
    step(1);
    i_ready = 1;
    wait_done(30);
    chk("t1_valid_cycles", vq.size(), 7);
    if (vq.size() == 7) begin
      chk("t1_v0", vq[0], 1020); chk("t1_v1", vq[1], 1021);
      chk("t1_v2", vq[2], 1022); chk("t1_v3", vq[3], 1022);
      chk("t1_v4", vq[4], 1023); chk("t1_v5", vq[5], 0);
      chk("t1_v6", vq[6], 1);
    end
    chk("t1_cnt", o_word_cnt, 6);
    chk("t1_one_done", done_cnt - d0, 1);

    // Down-count wrapping through zero
    start_burst(2'd1, 10'd1, 16'd3);
    wait_done(30);
    chk("t2_len", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("t2_w0", acc_q[0], 1); chk("t2_w1", acc_q[1], 0); chk("t2_w2", acc_q[2], 1023);
    end

    // LFSR from a zero seed, continuous, checked over a full period
    start_burst(2'd2, 10'd0, 16'd0);
    n = 0;
    while (acc_q.size() < 1025 && n < 1200) begin
      step(1);
      n++;
    end
    chk("t3_progress", acc_q.size() >= 1025, 1);
    i_stop = 1;
    step(1);
    i_stop = 0;
    wait_done(30);
    if (acc_q.size() >= 1025) begin
      chk("t3_w0", acc_q[0], 1);
      chk("t3_w1", acc_q[1], 2);
      chk("t3_w1024", acc_q[1023], 1);
    end
    zeros = 0;
    foreach (acc_q[i]) if (acc_q[i] == 0) zeros++;
    chk("t3_no_zero", zeros, 0);

    // Walking one
    start_burst(2'd3, 10'h200, 16'd3);
    wait_done(30);
    chk("t4_len", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("t4_w0", acc_q[0], 10'h200); chk("t4_w1", acc_q[1], 10'h001); chk("t4_w2", acc_q[2], 10'h002);
    end

    // Stop requested under back-pressure
    d0 = done_cnt;
    start_burst(2'd0, 10'd5, 16'd0);
    step(3);
    i_ready = 0;
    i_stop = 1;
    step(1);
    i_stop = 0;
    step(2);
    n = acc_q.size();
    i_ready = 1;
    wait_done(20);
    chk("t5_one_more_word", acc_q.size(), n + 1);
    chk("t5_one_done", done_cnt - d0, 1);
    chk("t5_valid_low", o_valid, 0);

    // Start together with stop in IDLE must not launch
    vq.delete();
    i_start = 1; i_stop = 1;
    step(1);
    i_start = 0; i_stop = 0;
    step(3);
    chk("t5_no_launch", vq.size(), 0);
    chk("t5_idle_busy", o_busy, 0);

    // Asynchronous reset in the middle of a burst
    d0 = done_cnt;
    start_burst(2'd0, 10'd100, 16'd0);
    step(4);
    #2;
    rst = 1;
    #1;
    chk("t6_valid", o_valid, 0);
    chk("t6_busy", o_busy, 0);
    chk("t6_data", o_data, 0);
    chk("t6_cnt", o_word_cnt, 0);
    step(2);
    rst = 0;
    step(3);
    chk("t6_no_done", done_cnt - d0, 0);

    // Randomized traffic, including start requests while running or finishing
    for (int c = 0; c < 3000; c++) begin
      i_ready = ($urandom_range(0, 3) != 0);
      i_start = ($urandom_range(0, 7) == 0);
      i_stop  = ($urandom_range(0, 39) == 0);
      i_mode  = 2'($urandom_range(0, 3));
      i_seed  = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom);
      i_len   = 16'($urandom_range(0, 12));
      step(1);
    end
    i_start = 0; i_ready = 1; i_stop = 1;
    step(3);
    i_stop = 0;
    step(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
